trig_sched_8: RTL and testbench

- Round-robin scheduler and sequencer for one shared 8-bit fixed-point sine/cosine evaluator (dp = 8, period 804 = 2π·128).
- Arbitrates up to NREQ requesters (audio effector LFOs, visualization sweeps).
- Per request: reduces the 16-bit angle modulo the period, folds to the first quadrant, and evaluates a 4th-order cosine polynomial over several cycles with a single time-shared multiplier.
- Returns a magnitude/sign result and a one-hot completion pulse.

---
 rtl/trig_sched_8.sv | 154 +++++++++++++++
 tb/tb_trig_sched_8.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/trig_sched_8.sv
// Round-robin scheduler around one time-shared 8-bit sine/cosine evaluator.
// Angle is reduced mod 804, folded to a quadrant, and fed to a 4th-order cosine polynomial.
module trig_sched_8 #(
    parameter int NREQ = 4,
    parameter int PER  = 804
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [16*NREQ-1:0] angle,
    input  logic [NREQ-1:0]   fn,
    output logic [NREQ-1:0]   done,
    output logic [7:0]        y,
    output logic              sig,
    output logic              busy
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [2:0] {
        S_IDLE, S_RED, S_FOLD, S_MA, S_MC, S_MD, S_DONE
    } state_t;

    state_t state, state_n;

    logic [IW-1:0] ptr, id, gnt;
    logic          gnt_vld;
    logic [16:0]   x, sub;
    logic [2:0]    k;
    logic [9:0]    mp, r, m_f, mp_f;
    logic          sgn_f, sig_n;
    logic [15:0]   a;
    logic [22:0]   c;
    logic [22:0]   mul_a;
    logic [11:0]   mul_b;
    logic [34:0]   prod;
    logic signed [11:0] t;
    logic [7:0]    y_n;

    // Rotating search: lowest offset from ptr+1 wins, so scan from the far end.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        for (int i = NREQ; i >= 1; i--) begin
            if (req[(int'(ptr) + i) % NREQ]) begin
                gnt     = IW'((int'(ptr) + i) % NREQ);
                gnt_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (gnt_vld) state_n = S_RED;
            S_RED:   if (k == 3'd0) state_n = S_FOLD;
            S_FOLD:  state_n = S_MA;
            S_MA:    state_n = S_MC;
            S_MC:    state_n = S_MD;
            S_MD:    state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
        done = '0;
        if (state == S_DONE) done = NREQ'(1) << id;
    end

    assign sub  = 17'(PER) << k;
    assign r    = x[9:0];
    assign m_f  = (r > 10'd402) ? 10'd804 - r : r;
    assign sgn_f = (m_f > 10'd201);
    assign mp_f = sgn_f ? 10'd402 - m_f : m_f;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            S_MA: begin
                mul_a = 23'(mp);
                mul_b = 12'(mp);
            end
            S_MC: begin
                mul_a = 23'(a[15:4]);
                mul_b = a[15:4];
            end
            S_MD: begin
                mul_a = c;
                mul_b = 12'd683;
            end
            default: ;
        endcase
    end

    assign prod = 35'(mul_a) * 35'(mul_b);

    // Polynomial tail evaluated straight off the MD product.
    assign t = 12'sd256 - $signed({3'b0, a[15:7]})
             + $signed({3'b0, prod[34:26]});
    assign y_n = t[11] ? 8'd0 : (t > 12'sd255) ? 8'd255 : t[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= IW'(NREQ - 1);
            id    <= '0;
            x     <= '0;
            k     <= '0;
            mp    <= '0;
            sig_n <= 1'b0;
            a     <= '0;
            c     <= '0;
            y     <= '0;
            sig   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gnt_vld) begin
                        id  <= gnt;
                        ptr <= gnt;
                        k   <= 3'd6;
                        if (fn[gnt])
                            x <= {1'b0, angle[{gnt, 4'b0} +: 16]} + 17'd603;
                        else
                            x <= {1'b0, angle[{gnt, 4'b0} +: 16]};
                    end
                end
                S_RED: begin
                    if (x >= sub) x <= x - sub;
                    k <= k - 3'd1;
                end
                S_FOLD: begin
                    mp    <= mp_f;
                    sig_n <= sgn_f;
                end
                S_MA: a <= prod[15:0];
                S_MC: c <= prod[22:0];
                S_MD: begin
                    y   <= y_n;
                    sig <= sig_n;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_trig_sched_8.sv
// Randomized and directed bench for trig_sched_8 against an arithmetic model.
// Checks latency, pulse width, round-robin order and async abort.
module tb_trig_sched_8;

    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [16*NREQ-1:0] angle = '0;
    logic [NREQ-1:0]   fn = '0;
    logic [NREQ-1:0]   done;
    logic [7:0]        y;
    logic              sig;
    logic              busy;

    int nvec = 0;
    int nerr = 0;

    trig_sched_8 #(.NREQ(NREQ), .PER(804)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .angle(angle),
        .fn(fn), .done(done), .y(y), .sig(sig), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // {sig, y} from the plain arithmetic definition
    function automatic logic [8:0] model(input int ang, input bit f);
        int xx, rr, m, mp, a, c, t;
        longint d;
        bit s;
        xx = ang + (f ? 603 : 0);
        rr = xx % 804;
        m  = (rr > 402) ? 804 - rr : rr;
        s  = (m > 201);
        mp = s ? 402 - m : m;
        a  = mp * mp;
        c  = (a / 16) * (a / 16);
        d  = longint'(c) * 683;
        t  = 256 - a / 128 + int'(d / (longint'(1) << 26));
        if (t < 0) t = 0;
        if (t > 255) t = 255;
        return {s, 8'(t)};
    endfunction

    // Next posedge must be the sampling edge for requester id.
    task automatic wait_done(input int id, input int ang, input bit f);
        logic [8:0] e;
        bit got;
        e = model(ang, f);
        got = 0;
        @(posedge clk);
        for (int n = 1; n <= 20 && !got; n++) begin
            @(negedge clk);
            if (n == 1) chk("busy_on", busy, 1);
            if (done != 0) begin
                got = 1;
                chk("latency", n, 12);
                chk("done_id", done, longint'(1) << id);
                chk("y", y, e[7:0]);
                chk("sig", sig, e[8]);
                req[id] = 1'b0;
            end
        end
        if (!got) chk("timeout", 0, 1);
        @(negedge clk);
        chk("done_width", done, 0);
        chk("busy_off", busy, 0);
    endtask

    task automatic run_one(input int id, input int ang, input bit f);
        @(negedge clk);
        angle[16*id +: 16] = 16'(ang);
        fn[id]  = f;
        req[id] = 1'b1;
        wait_done(id, ang, f);
    endtask

    int dir_ang[10] = '{0, 100, 402, 804, 704, 0, 201, 301, 65535, 65535};
    bit dir_fn[10]  = '{0, 0, 0, 0, 0, 1, 1, 1, 0, 1};
    int ord[9] = '{0, 1, 2, 3, 0, 1, 2, 0, 2};

    initial begin
        int ra[NREQ];
        bit rf[NREQ];
        int kk, last, ang;
        bit f;
        logic [8:0] e;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_done", done, 0);
        chk("rst_y", y, 0);
        chk("rst_sig", sig, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            run_one(i % NREQ, dir_ang[i], dir_fn[i]);

        for (int i = 0; i < 40; i++)
            run_one(int'($urandom_range(0, NREQ - 1)),
                    int'($urandom_range(0, 65535)), 1'($urandom));

        // All requesters held high from reset
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = int'($urandom_range(0, 65535));
            rf[i] = 1'($urandom);
            angle[16*i +: 16] = 16'(ra[i]);
            fn[i] = rf[i];
        end
        req = '1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        kk = 0;
        last = 0;
        for (int n = 1; n <= 200 && kk < 9; n++) begin
            @(negedge clk);
            if (done != 0) begin
                e = model(ra[ord[kk]], rf[ord[kk]]);
                chk("arb_order", done, longint'(1) << ord[kk]);
                chk("arb_y", y, e[7:0]);
                chk("arb_sig", sig, e[8]);
                if (kk > 0) chk("arb_gap", n - last, 13);
                last = n;
                kk++;
                if (kk == 6) req = 4'b0101;
                if (kk == 9) req = '0;
            end
        end
        if (kk < 9) chk("arb_timeout", kk, 9);
        req = '0;
        repeat (2) @(negedge clk);

        // Async reset while in MC aborts; pending request restarts
        ang = int'($urandom_range(0, 65535));
        f = 1'($urandom);
        angle[16 +: 16] = 16'(ang);
        fn[1] = f;
        req[1] = 1'b1;
        @(posedge clk);
        repeat (10) @(negedge clk);
        chk("pre_abort_busy", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_y", y, 0);
        chk("abort_sig", sig, 0);
        @(negedge clk);
        chk("abort_hold", done, 0);
        rst_n = 1'b1;
        wait_done(1, ang, f);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
